// File: rtl/voice_allocator.sv
// Polyphonic key-to-voice scheduler: synchronises the active-low button bank,
// queues new presses and hands them to shared oscillator voices one per clock,
// stealing the oldest voice when none is free.
module voice_allocator #(
  parameter int unsigned NUM_KEYS   = 8,
  parameter int unsigned NUM_VOICES = 3,
  parameter int unsigned KEY_W      = $clog2(NUM_KEYS),
  parameter int unsigned AGE_W      = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_KEYS-1:0]         btn,
  output logic [NUM_VOICES-1:0]       voice_gate,
  output logic [NUM_VOICES*KEY_W-1:0] voice_key,
  output logic                        steal,
  output logic                        pending_any,
  output logic [5:0]                  led
);

  localparam int unsigned VIDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;

  logic [NUM_KEYS-1:0]   sync1_q, sync2_q, prev_q;
  logic [NUM_KEYS-1:0]   pending_q, pending_d;
  logic [NUM_KEYS-1:0]   pressed, released;
  logic [NUM_VOICES-1:0] gate_q, gate_d, gate_rel;
  logic [KEY_W-1:0]      key_q [NUM_VOICES];
  logic [KEY_W-1:0]      key_d [NUM_VOICES];
  logic [AGE_W-1:0]      age_q [NUM_VOICES];
  logic [AGE_W-1:0]      age_d [NUM_VOICES];
  logic                  steal_q, steal_d;

  logic                  cand_ok, free_ok;
  logic [KEY_W-1:0]      cand;
  logic [VIDX_W-1:0]     free_v, old_v, tgt_v;
  logic [AGE_W-1:0]      old_age;

  // Edge detect on the synchronised bank and apply releases to sounding voices.
  always_comb begin
    pressed  = ~sync2_q & prev_q;
    released = sync2_q & ~prev_q;
    gate_rel = gate_q;
    for (int v = 0; v < NUM_VOICES; v++) begin
      for (int k = 0; k < NUM_KEYS; k++) begin
        if (released[k] && key_q[v] == KEY_W'(k)) gate_rel[v] = 1'b0;
      end
    end
  end

  // Pick the lowest pending key and the voice it lands on.
  always_comb begin
    cand_ok = 1'b0;
    cand    = '0;
    // A key released in this very cycle is withdrawn, never voiced.
    for (int k = NUM_KEYS - 1; k >= 0; k--) begin
      if (pending_q[k] && !released[k]) begin
        cand_ok = 1'b1;
        cand    = KEY_W'(k);
      end
    end
    free_ok = 1'b0;
    free_v  = '0;
    for (int v = NUM_VOICES - 1; v >= 0; v--) begin
      if (!gate_rel[v]) begin
        free_ok = 1'b1;
        free_v  = VIDX_W'(v);
      end
    end
    // Oldest voice; strict compare keeps ties on the lowest index.
    old_v   = '0;
    old_age = age_q[0];
    for (int v = 1; v < NUM_VOICES; v++) begin
      if (age_q[v] > old_age) begin
        old_age = age_q[v];
        old_v   = VIDX_W'(v);
      end
    end
    tgt_v = free_ok ? free_v : old_v;
  end

  // Next-state for pending queue, voices and ages.
  always_comb begin
    gate_d    = gate_rel;
    key_d     = key_q;
    age_d     = age_q;
    steal_d   = 1'b0;
    pending_d = pending_q & ~released;
    if (cand_ok) begin
      steal_d = ~free_ok;
      for (int v = 0; v < NUM_VOICES; v++) begin
        if (VIDX_W'(v) == tgt_v) begin
          gate_d[v] = 1'b1;
          key_d[v]  = cand;
          age_d[v]  = '0;
        end else if (gate_rel[v] && age_q[v] != '1) begin
          age_d[v] = age_q[v] + 1'b1;
        end
      end
      for (int k = 0; k < NUM_KEYS; k++) begin
        if (KEY_W'(k) == cand) pending_d[k] = 1'b0;
      end
    end
    pending_d = pending_d | pressed;
  end

  // Two-flop synchroniser plus edge register; idle level is all released.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= '1;
      sync2_q <= '1;
      prev_q  <= '1;
    end else begin
      sync1_q <= btn;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  // Voice and queue state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q <= '0;
      gate_q    <= '0;
      steal_q   <= 1'b0;
      for (int v = 0; v < NUM_VOICES; v++) begin
        key_q[v] <= '0;
        age_q[v] <= '0;
      end
    end else begin
      pending_q <= pending_d;
      gate_q    <= gate_d;
      steal_q   <= steal_d;
      key_q     <= key_d;
      age_q     <= age_d;
    end
  end

  // Pack per-voice keys onto the flat output bus.
  always_comb begin
    voice_key = '0;
    for (int v = 0; v < NUM_VOICES; v++) voice_key[v*KEY_W +: KEY_W] = key_q[v];
  end

  assign voice_gate  = gate_q;
  assign steal       = steal_q;
  assign pending_any = |pending_q;

  for (genvar i = 0; i < 6; i++) begin : g_led
    if (i < NUM_KEYS) begin : g_key
      assign led[i] = ~sync2_q[i];
    end else begin : g_pad
      assign led[i] = 1'b0;
    end
  end

endmodule

// File: tb/tb_voice_allocator.sv
// Bench for voice_allocator: directed press/release scenarios checked against
// a per-cycle behavioural model plus hand-computed literal expectations.
module tb_voice_allocator;

  localparam int NK      = 8;
  localparam int NV      = 3;
  localparam int KW      = 3;
  localparam int AW      = 4;
  localparam int AGE_MAX = (1 << AW) - 1;

  logic            clk = 1'b0;
  logic            rst_n;
  logic [NK-1:0]   btn;
  logic [NV-1:0]   voice_gate;
  logic [NV*KW-1:0] voice_key;
  logic            steal;
  logic            pending_any;
  logic [5:0]      led;

  int n_checks = 0;
  int n_fail   = 0;
  bit chk_en   = 1'b0;

  voice_allocator #(
    .NUM_KEYS  (NK),
    .NUM_VOICES(NV),
    .KEY_W     (KW),
    .AGE_W     (AW)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .btn        (btn),
    .voice_gate (voice_gate),
    .voice_key  (voice_key),
    .steal      (steal),
    .pending_any(pending_any),
    .led        (led)
  );

  always #5 clk = ~clk;

  // Behavioural model state: what the voices hold, in plain ints.
  bit          m_gate [NV];
  int          m_key  [NV];
  int          m_age  [NV];
  bit          m_pend [NK];
  bit          m_steal;
  logic [NK-1:0] m_s1, m_s2, m_prev;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int v = 0; v < NV; v++) begin
      m_gate[v] = 1'b0;
      m_key[v]  = 0;
      m_age[v]  = 0;
    end
    for (int k = 0; k < NK; k++) m_pend[k] = 1'b0;
    m_steal = 1'b0;
    m_s1    = '1;
    m_s2    = '1;
    m_prev  = '1;
  endtask

  // One clock of the allocation rules: release first, then one allocation.
  task automatic model_step();
    bit prs [NK];
    bit rel [NK];
    int cand;
    int tgt;
    int best;
    for (int k = 0; k < NK; k++) begin
      prs[k] = !m_s2[k] && m_prev[k];
      rel[k] = m_s2[k] && !m_prev[k];
    end
    for (int v = 0; v < NV; v++) if (m_gate[v] && rel[m_key[v]]) m_gate[v] = 1'b0;
    cand = -1;
    for (int k = NK - 1; k >= 0; k--) if (m_pend[k] && !rel[k]) cand = k;
    for (int k = 0; k < NK; k++) if (rel[k]) m_pend[k] = 1'b0;
    m_steal = 1'b0;
    if (cand >= 0) begin
      tgt = -1;
      for (int v = NV - 1; v >= 0; v--) if (!m_gate[v]) tgt = v;
      if (tgt < 0) begin
        best = -1;
        for (int v = 0; v < NV; v++) begin
          if (m_age[v] > best) begin
            best = m_age[v];
            tgt  = v;
          end
        end
        m_steal = 1'b1;
      end
      for (int v = 0; v < NV; v++) begin
        if (v == tgt) begin
          m_gate[v] = 1'b1;
          m_key[v]  = cand;
          m_age[v]  = 0;
        end else if (m_gate[v]) begin
          m_age[v] = (m_age[v] < AGE_MAX) ? m_age[v] + 1 : AGE_MAX;
        end
      end
      m_pend[cand] = 1'b0;
    end
    for (int k = 0; k < NK; k++) if (prs[k]) m_pend[k] = 1'b1;
    m_prev = m_s2;
    m_s2   = m_s1;
    m_s1   = btn;
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_step();
    end
  end

  // Compare DUT against the model on every falling edge.
  initial begin
    logic [NV-1:0]    e_gate;
    logic [NV*KW-1:0] e_key;
    logic             e_pa;
    logic [5:0]       e_led;
    forever begin
      @(negedge clk);
      if (chk_en) begin
        e_gate = '0;
        e_key  = '0;
        e_pa   = 1'b0;
        for (int v = 0; v < NV; v++) begin
          e_gate[v]          = m_gate[v];
          e_key[v*KW +: KW]  = KW'(m_key[v]);
        end
        for (int k = 0; k < NK; k++) e_pa = e_pa | m_pend[k];
        e_led = ~m_s2[5:0];
        check("model_gate", 32'(voice_gate), 32'(e_gate));
        check("model_key", 32'(voice_key), 32'(e_key));
        check("model_steal", 32'(steal), 32'(m_steal));
        check("model_pending_any", 32'(pending_any), 32'(e_pa));
        check("model_led", 32'(led), 32'(e_led));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b1;
    btn   = 8'h00;
    #1 rst_n = 1'b0;
    chk_en = 1'b1;

    // 1: reset with every button pressed, then key 0 voiced at E3
    repeat (3) tick();
    check("rst_gate", 32'(voice_gate), 32'h0);
    check("rst_key", 32'(voice_key), 32'h0);
    check("rst_pending_any", 32'(pending_any), 32'h0);
    check("rst_led", 32'(led), 32'h0);
    btn   = 8'hFE;
    rst_n = 1'b1;
    tick();
    check("t1_e0_gate", 32'(voice_gate), 32'h0);
    tick();
    check("t1_e1_led", 32'(led), 32'h01);
    tick();
    check("t1_e2_pending", 32'(pending_any), 32'h1);
    check("t1_e2_gate", 32'(voice_gate), 32'h0);
    tick();
    check("t1_e3_gate", 32'(voice_gate), 32'h1);
    check("t1_e3_key", 32'(voice_key), 32'h0);
    btn = 8'hFF;
    repeat (4) tick();
    check("t1_release_gate", 32'(voice_gate), 32'h0);

    // 2: keys 0,1,2 together fill voices 0,1,2 on consecutive clocks
    btn = 8'hF8;
    repeat (3) tick();
    check("t2_e2_pending", 32'(pending_any), 32'h1);
    check("t2_e2_gate", 32'(voice_gate), 32'h0);
    tick();
    check("t2_e3_gate", 32'(voice_gate), 32'h1);
    tick();
    check("t2_e4_gate", 32'(voice_gate), 32'h3);
    check("t2_e4_pending", 32'(pending_any), 32'h1);
    tick();
    check("t2_e5_gate", 32'(voice_gate), 32'h7);
    check("t2_e5_pending", 32'(pending_any), 32'h0);
    check("t2_e5_key", 32'(voice_key), 32'(9'b010_001_000));
    check("t2_e5_steal", 32'(steal), 32'h0);

    // 3: key 3 steals the oldest voice (0); releasing stolen key 0 is a no-op
    btn = 8'hF0;
    repeat (4) tick();
    check("t3_steal_pulse", 32'(steal), 32'h1);
    check("t3_gate", 32'(voice_gate), 32'h7);
    check("t3_key", 32'(voice_key), 32'(9'b010_001_011));
    tick();
    check("t3_steal_end", 32'(steal), 32'h0);
    btn = 8'hF1;
    repeat (4) tick();
    check("t3_stolen_release_gate", 32'(voice_gate), 32'h7);

    // 4: release key 1 frees voice 1, key 5 reuses it without stealing
    btn = 8'hF3;
    repeat (2) tick();
    check("t4_e1_gate", 32'(voice_gate), 32'h7);
    tick();
    check("t4_e2_gate", 32'(voice_gate), 32'h5);
    btn = 8'hD3;
    repeat (4) tick();
    check("t4_gate", 32'(voice_gate), 32'h7);
    check("t4_key", 32'(voice_key), 32'(9'b010_101_011));
    check("t4_steal", 32'(steal), 32'h0);

    // 5: keys 0,1,4,6 queued; key 4 let go before its turn is never voiced
    btn = 8'h80;
    tick();
    btn = 8'h90;
    repeat (2) tick();
    check("t5_e2_pending", 32'(pending_any), 32'h1);
    repeat (4) tick();
    check("t5_pending", 32'(pending_any), 32'h0);
    check("t5_gate", 32'(voice_gate), 32'h7);
    check("t5_key", 32'(voice_key), 32'(9'b000_110_001));
    check("t5_steal", 32'(steal), 32'h0);

    // 6: reset with three voices up and keys 4,7 pending
    btn = 8'h00;
    repeat (3) tick();
    check("t6_pre_pending", 32'(pending_any), 32'h1);
    check("t6_pre_gate", 32'(voice_gate), 32'h7);
    rst_n = 1'b0;
    #1;
    check("t6_rst_gate", 32'(voice_gate), 32'h0);
    check("t6_rst_pending", 32'(pending_any), 32'h0);
    check("t6_rst_key", 32'(voice_key), 32'h0);
    check("t6_rst_led", 32'(led), 32'h0);
    btn = 8'hFF;
    repeat (2) tick();
    rst_n = 1'b1;
    repeat (6) tick();
    check("t6_idle_gate", 32'(voice_gate), 32'h0);
    check("t6_idle_pending", 32'(pending_any), 32'h0);
    check("t6_idle_steal", 32'(steal), 32'h0);
    check("t6_idle_led", 32'(led), 32'h0);

    @(negedge clk);
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
